// File: rtl/hmm_seq_gen_pkg.sv
// Shared types and constants for the HMM sequence generator and its decoder bench.
package hmm_seq_gen_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned I     = 3;
  localparam int unsigned K     = 3;
  localparam int unsigned P     = 16;

  localparam int unsigned LEN_W = $clog2(N + 1);
  localparam int unsigned T_W   = $clog2(N);
  localparam int unsigned S_W   = $clog2(I);
  localparam int unsigned O_W   = $clog2(K);
  localparam int unsigned M_MAX = (I > K) ? I : K;
  localparam int unsigned IDX_W = $clog2(M_MAX);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_DRAW_S,
    S_DRAW_O,
    S_EMIT,
    S_FINISH
  } gen_state_e;

  typedef struct packed {
    logic [T_W-1:0] t;
    logic [S_W-1:0] state;
    logic [O_W-1:0] obs;
  } obs_beat_t;

  // One Galois right-shift step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/hmm_seq_gen_if.sv
// Observation stream from the generator to a consumer (e.g. a Viterbi decoder).
interface hmm_seq_gen_if;
  import hmm_seq_gen_pkg::*;

  logic [O_W-1:0] obs_out;
  logic [S_W-1:0] state_out;
  logic [T_W-1:0] t_out;
  logic           obs_valid;
  logic           obs_ready;

  modport master (output obs_out, state_out, t_out, obs_valid, input obs_ready);
  modport slave  (input obs_out, state_out, t_out, obs_valid, output obs_ready);
endinterface

// File: rtl/hmm_seq_gen_cdf_sampler.sv
// First-threshold CDF search: index of the first entry above r, last index if none.
module hmm_seq_gen_cdf_sampler #(
  parameter int unsigned M  = 3,
  parameter int unsigned P  = 16,
  parameter int unsigned IW = $clog2(M)
) (
  input  logic [M-1:0][P-1:0] cdf,
  input  logic [P-1:0]        r,
  output logic [IW-1:0]       idx_c
);

  always_comb begin
    idx_c = IW'(M - 1);
    for (int j = int'(M) - 1; j >= 0; j--) begin
      if (r < cdf[j]) idx_c = IW'(j);
    end
  end

endmodule

// File: rtl/hmm_seq_gen.sv
// HMM hidden-state path and observation stream generator driven by an LFSR.
// Optional HMM_GEN_PATH_BUF_EN adds a state_path buffer written at each handshake.
module hmm_seq_gen
  import hmm_seq_gen_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_W-1:0]            length,
  input  logic [31:0]                 seed,
  input  logic [I-1:0][P-1:0]         cdfC,
  input  logic [I-1:0][I-1:0][P-1:0]  cdfA,
  input  logic [I-1:0][K-1:0][P-1:0]  cdfB,
`ifdef HMM_GEN_PATH_BUF_EN
  output logic [0:N-1][S_W-1:0]       state_path,
`endif
  output logic                        done,
  hmm_seq_gen_if.master               obs_if
);

  gen_state_e      state_q, state_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [T_W-1:0]  t_q, t_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [S_W-1:0]  cur_q, cur_d;
  obs_beat_t       beat_q, beat_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
`ifdef HMM_GEN_PATH_BUF_EN
  logic [0:N-1][S_W-1:0] path_q, path_d;
`endif

  logic [M_MAX-1:0][P-1:0] cdf_row;
  logic [IDX_W-1:0]        samp_idx_c;
  logic [S_W-1:0]          st_idx;
  logic [O_W-1:0]          ob_idx;
  logic                    last_sym;

  // Row select: initial/transition row while drawing the state, emission row while drawing obs.
  always_comb begin
    cdf_row = '0;
    for (int j = 0; j < int'(M_MAX); j++) begin
      if (state_q == S_DRAW_S && j < int'(I)) begin
        if (t_q == '0) begin
          cdf_row[j] = cdfC[j];
        end else begin
          for (int i = 0; i < int'(I); i++) begin
            if (cur_q == S_W'(i)) cdf_row[j] = cdfA[i][j];
          end
        end
      end else if (state_q == S_DRAW_O && j < int'(K)) begin
        for (int i = 0; i < int'(I); i++) begin
          if (cur_q == S_W'(i)) cdf_row[j] = cdfB[i][j];
        end
      end
    end
  end

  hmm_seq_gen_cdf_sampler #(.M(M_MAX), .P(P), .IW(IDX_W)) u_sampler (
    .cdf   (cdf_row),
    .r     (lfsr_q[P-1:0]),
    .idx_c (samp_idx_c)
  );

  // Zero padding falls through to the shared last index; clamp to the row's own last index.
  assign st_idx   = (samp_idx_c >= IDX_W'(I)) ? S_W'(I - 1) : S_W'(samp_idx_c);
  assign ob_idx   = (samp_idx_c >= IDX_W'(K)) ? O_W'(K - 1) : O_W'(samp_idx_c);
  assign last_sym = (LEN_W'(t_q) + LEN_W'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    t_d     = t_q;
    len_d   = len_q;
    cur_d   = cur_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    done_d  = done_q;
`ifdef HMM_GEN_PATH_BUF_EN
    path_d  = path_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEED;
          len_d   = (length > LEN_W'(N)) ? LEN_W'(N) : length;
        end
      end
      S_SEED: begin
        lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
        t_d    = '0;
        done_d = 1'b0;
`ifdef HMM_GEN_PATH_BUF_EN
        path_d = '0;
`endif
        if (len_q == '0) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAW_S;
        end
      end
      S_DRAW_S: begin
        cur_d   = st_idx;
        lfsr_d  = lfsr_step(lfsr_q);
        state_d = S_DRAW_O;
      end
      S_DRAW_O: begin
        beat_d  = '{t: t_q, state: cur_q, obs: ob_idx};
        lfsr_d  = lfsr_step(lfsr_q);
        valid_d = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (obs_if.obs_ready) begin
          valid_d = 1'b0;
`ifdef HMM_GEN_PATH_BUF_EN
          path_d[t_q] = cur_q;
`endif
          if (last_sym) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            t_d     = t_q + T_W'(1);
            state_d = S_DRAW_S;
          end
        end
      end
      S_FINISH: begin
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 32'd1;
      t_q     <= '0;
      len_q   <= '0;
      cur_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef HMM_GEN_PATH_BUF_EN
      path_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      t_q     <= t_d;
      len_q   <= len_d;
      cur_q   <= cur_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef HMM_GEN_PATH_BUF_EN
      path_q  <= path_d;
`endif
    end
  end

  assign obs_if.obs_out   = beat_q.obs;
  assign obs_if.state_out = beat_q.state;
  assign obs_if.t_out     = beat_q.t;
  assign obs_if.obs_valid = valid_q;
  assign done             = done_q;
`ifdef HMM_GEN_PATH_BUF_EN
  assign state_path       = path_q;
`endif

endmodule
